// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and frame timing helpers for the UART blocks.
package uart_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } state_t;

    function automatic int frame_len(input int width, input int clks_per_bit);
        return (width + 2) * clks_per_bit;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// baud_tick_gen: free-running bit-period counter with clear; tick marks the last cycle of a bit.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q;

    assign tick_o = cnt_q == CNT_W'(CLKS_PER_BIT - 1);
    assign cnt_o  = cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i || tick_o) cnt_q <= '0;
        else                        cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a registered-output FIFO and sends each as a start/data/stop frame.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [IDX_W-1:0] idx_q;
    logic             tx_q, busy_q, done_q;
    logic [CNT_W-1:0] cnt;
    logic             tick;

    assign fifo_rd_en = (state_q == IDLE) && en && !fifo_empty && !rst;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == IDLE || state_q == LOAD),
        .cnt_o  (cnt),
        .tick_o (tick)
    );

    // tx/busy/frame_done are registered, so each is set on the edge entering the cycle it describes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (fifo_rd_en) begin
                    state_q <= LOAD;
                    busy_q  <= 1'b1;
                end
                LOAD: begin
                    shift_q <= fifo_rdata;
                    idx_q   <= '0;
                    tx_q    <= 1'b0;
                    state_q <= START;
                end
                START: if (tick) begin
                    tx_q    <= shift_q[0];
                    state_q <= DATA;
                end
                DATA: if (tick) begin
                    shift_q <= shift_q >> 1;
                    if (idx_q == IDX_W'(WIDTH - 1)) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        tx_q  <= shift_q[1];
                        idx_q <= idx_q + 1'b1;
                    end
                end
                STOP: begin
                    done_q <= cnt == CNT_W'(CLKS_PER_BIT - 2);
                    if (tick) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives fifo_uart_tx from a behavioural FIFO and checks line timing against a frame model.
module tb_fifo_uart_tx;

    localparam int W     = 8;
    localparam int CPB   = 4;
    localparam int FL    = (W + 2) * CPB;
    localparam int P     = FL + 2;
    localparam int DEPTH = 16;
    localparam int MAXC  = 800;

    logic         clk = 1'b0, rst = 1'b1, en = 1'b0, fifo_empty = 1'b1;
    logic [W-1:0] fifo_rdata = '0;
    logic         fifo_rd_en, tx, busy, frame_done;
    logic         wr = 1'b0, fclr = 1'b0, overflow = 1'b0, underflow = 1'b0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] mem[$];

    int checks = 0, errors = 0;
    logic [3:0] cap[0:MAXC-1];
    int nf;
    int st[0:19], lim[0:19];
    logic [W-1:0] by[0:19];

    always #5 clk = ~clk;

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // upstream FIFO: registered read data, sticky overflow/underflow flags
    always @(posedge clk) begin
        if (fclr) begin
            mem.delete();
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (fifo_rd_en) begin
                if (mem.size() == 0) underflow <= 1'b1;
                else fifo_rdata <= mem.pop_front();
            end
            if (wr) begin
                if (mem.size() >= DEPTH) overflow <= 1'b1;
                else mem.push_back(wdata);
            end
        end
        fifo_empty <= (mem.size() == 0);
    end

    function automatic logic frame_bit(input int off, input logic [W-1:0] b);
        int bi;
        if (off < 0 || off >= FL) return 1'b1;
        bi = off / CPB;
        return (bi == 0) ? 1'b0 : (bi == W + 1) ? 1'b1 : b[bi-1];
    endfunction

    // expected {rd_en, tx, busy, frame_done} at cycle k for the frames listed in st/by/lim
    function automatic logic [3:0] expv(input int k);
        logic r, t, b, d;
        r = 1'b0; t = 1'b1; b = 1'b0; d = 1'b0;
        for (int i = 0; i < nf; i++) begin
            if (k < lim[i]) begin
                r = r | (k == st[i]);
                t = t & frame_bit(k - st[i] - 2, by[i]);
                b = b | (k > st[i] && k <= st[i] + FL + 1);
                d = d | (k == st[i] + FL + 1);
            end
        end
        return {r, t, b, d};
    endfunction

    task automatic push(input logic [W-1:0] v);
        wr = 1'b1; wdata = v;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic clear_fifo();
        fclr = 1'b1;
        @(negedge clk);
        fclr = 1'b0;
        @(negedge clk);
    endtask

    task automatic capture(input int n, input int en_from, input int en_to, input int rst_at);
        for (int k = 0; k < n; k++) begin
            en  = (k >= en_from && k < en_to);
            rst = (k == rst_at);
            #1;
            cap[k] = {fifo_rd_en, tx, busy, frame_done};
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1;
        repeat (2) @(negedge clk);
        push(8'h11);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if ({fifo_rd_en, tx, busy, frame_done} !== 4'b0100) begin
                errors++;
                $display("FAIL reset cycle %0d got rd/tx/busy/done=%b expected 0100", k, {fifo_rd_en, tx, busy, frame_done});
            end
            @(negedge clk);
        end
        en = 1'b0;
        clear_fifo();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        en = 1'b1;
        push(8'hA5);
        capture(46, 0, 1000, -1);
        nf = 1; st[0] = 0; by[0] = 8'hA5; lim[0] = 1 << 30;
        for (int k = 0; k < 46; k++) begin
            checks++;
            if (cap[k] !== expv(k)) begin
                errors++;
                $display("FAIL single cycle %0d got %b expected %b", k, cap[k], expv(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] v[3] = '{8'h00, 8'hFF, 8'h3C};
        en = 1'b0;
        foreach (v[i]) push(v[i]);
        capture(130, 0, 1000, -1);
        nf = 3;
        for (int i = 0; i < 3; i++) begin st[i] = i * P; by[i] = v[i]; lim[i] = 1 << 30; end
        for (int k = 0; k < 130; k++) begin
            checks++;
            if (cap[k] !== expv(k)) begin
                errors++;
                $display("FAIL b2b cycle %0d got %b expected %b", k, cap[k], expv(k));
            end
        end
        checks++;
        if ({underflow, fifo_empty} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_flags got underflow/empty=%b expected 01", {underflow, fifo_empty});
        end
    endtask

    task automatic test_empty_idle();
        capture(100, 0, 1000, -1);
        nf = 0;
        for (int k = 0; k < 100; k++) begin
            checks++;
            if (cap[k] !== 4'b0100) begin
                errors++;
                $display("FAIL empty_idle cycle %0d got %b expected 0100", k, cap[k]);
            end
        end
    endtask

    task automatic test_en_gate();
        logic [W-1:0] a, b;
        a = W'($urandom); b = W'($urandom);
        en = 1'b0;
        push(a); push(b);
        capture(100, 50, 60, -1);
        nf = 1; st[0] = 50; by[0] = a; lim[0] = 1 << 30;
        for (int k = 0; k < 100; k++) begin
            checks++;
            if (cap[k] !== expv(k)) begin
                errors++;
                $display("FAIL en_gate cycle %0d got %b expected %b", k, cap[k], expv(k));
            end
        end
        checks++;
        if (mem.size() != 1) begin
            errors++;
            $display("FAIL en_gate_left got %0d words expected 1", mem.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] b;
        b = W'($urandom);
        en = 1'b0;
        clear_fifo();
        push(8'h5A); push(b);
        capture(70, 0, 1000, 20);
        nf = 2;
        st[0] = 0;  by[0] = 8'h5A; lim[0] = 21;
        st[1] = 21; by[1] = b;     lim[1] = 1 << 30;
        for (int k = 0; k < 70; k++) begin
            checks++;
            if (cap[k] !== expv(k)) begin
                errors++;
                $display("FAIL rst_mid cycle %0d got %b expected %b", k, cap[k], expv(k));
            end
        end
    endtask

    task automatic test_overflow_drain();
        logic [W-1:0] sent[$];
        logic [W-1:0] v;
        int n, nd;
        en = 1'b0;
        clear_fifo();
        for (int i = 0; i < 20; i++) begin
            v = W'($urandom);
            if (i < DEPTH) sent.push_back(v);
            push(v);
            if (i == DEPTH - 1 || i == DEPTH) begin
                checks++;
                if (overflow !== (i == DEPTH)) begin
                    errors++;
                    $display("FAIL overflow after %0d writes got %b expected %b", i + 1, overflow, i == DEPTH);
                end
            end
        end
        n = DEPTH * P + 10;
        capture(n, 0, 100000, -1);
        nf = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin st[i] = i * P; by[i] = sent[i]; lim[i] = 1 << 30; end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (cap[k] !== expv(k)) begin
                errors++;
                $display("FAIL drain cycle %0d got %b expected %b", k, cap[k], expv(k));
            end
        end
        nd = 0;
        for (int k = 1; k < n - FL; k++) begin
            if (cap[k-1][2] === 1'b1 && cap[k][2] === 1'b0) begin
                for (int j = 0; j < W; j++) v[j] = cap[k + CPB * (j + 1) + CPB / 2][2];
                checks++;
                if (nd >= DEPTH || v !== sent[nd] || cap[k + CPB * (W + 1) + CPB / 2][2] !== 1'b1) begin
                    errors++;
                    $display("FAIL decode frame %0d got %h expected %h", nd, v, (nd < DEPTH) ? sent[nd] : 8'hxx);
                end
                nd++;
                k += FL - 1;
            end
        end
        checks++;
        if (nd != DEPTH || underflow !== 1'b0) begin
            errors++;
            $display("FAIL drain_count got %0d frames underflow=%b expected %0d frames underflow=0", nd, underflow, DEPTH);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_empty_idle();
        test_en_gate();
        test_reset_mid_frame();
        test_overflow_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
